// File: rtl/clk_div_cfg.sv
// Divide-factor front-end for the clock divider: handshakes new factors in and applies them only on the divider's wrap edge.
// Optional CLK_DIV_CFG_RESYNC_EN: realign the shadow counter to div_clk_out after a sync loss.
module clk_div_cfg #(
  parameter int          WIDTH   = 32,
  parameter int unsigned N_RESET = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_n,
  output logic             cfg_ready,
  input  logic             div_clk_out,
  output logic [WIDTH-1:0] n_out,
  output logic             busy,
  output logic             applied,
  output logic             err_zero,
  output logic             err_sync,
  input  logic             err_clr
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] N_RESET_W = WIDTH'(N_RESET);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] n_out_reg, n_out_next;
  logic [WIDTH-1:0] pend_n_reg, pend_n_next;
  logic [WIDTH-1:0] shadow_reg, shadow_next;
  logic             exp_clk_reg, exp_clk_next;
  logic             applied_reg, applied_next;
  logic             err_zero_reg, err_zero_next;
  logic             err_sync_reg, err_sync_next;

  logic             wrap;
  logic             mismatch;
  logic             blocked;
  logic             zero_set;

`ifdef CLK_DIV_CFG_RESYNC_EN
  logic             unsync_reg, unsync_next;
  logic             div_prev_reg;
  assign blocked = unsync_reg;
`else
  assign blocked = 1'b0;
`endif

  // Shadow counter mirrors the divider, so wrap marks the divider's own wrap edge.
  assign wrap     = (shadow_reg == (n_out_reg - ONE_W));
  assign mismatch = (div_clk_out != exp_clk_reg);

  // Shadow model of the divider's counter and clk_out
  always_comb begin
    shadow_next  = shadow_reg + ONE_W;
    exp_clk_next = exp_clk_reg;
    if (wrap) begin
      shadow_next  = '0;
      exp_clk_next = ~exp_clk_reg;
    end
`ifdef CLK_DIV_CFG_RESYNC_EN
    unsync_next = unsync_reg;
    // A toggle of div_clk_out means the divider count has just returned to 0.
    if (unsync_reg && (div_clk_out != div_prev_reg)) begin
      unsync_next = 1'b0;
      if (n_out_reg == ONE_W) begin
        shadow_next  = '0;
        exp_clk_next = ~div_clk_out;
      end else begin
        shadow_next  = ONE_W;
        exp_clk_next = div_clk_out;
      end
    end else if (mismatch) begin
      unsync_next = 1'b1;
    end
`endif
  end

  // Handshake / apply state machine
  always_comb begin
    state_next   = state_reg;
    n_out_next   = n_out_reg;
    pend_n_next  = pend_n_reg;
    applied_next = 1'b0;
    zero_set     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_n == '0) begin
            zero_set = 1'b1;
          end else begin
            pend_n_next = cfg_n;
            state_next  = PEND;
          end
        end
      end
      PEND: begin
        // A request accepted on a wrap edge sees state IDLE there, so it waits a full period.
        if (wrap && !blocked) begin
          n_out_next   = pend_n_reg;
          applied_next = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sticky errors: a set on the same edge beats the clear.
  always_comb begin
    err_zero_next = zero_set | (err_zero_reg & ~err_clr);
    err_sync_next = mismatch | (err_sync_reg & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      n_out_reg    <= N_RESET_W;
      pend_n_reg   <= '0;
      shadow_reg   <= '0;
      exp_clk_reg  <= 1'b0;
      applied_reg  <= 1'b0;
      err_zero_reg <= 1'b0;
      err_sync_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      n_out_reg    <= n_out_next;
      pend_n_reg   <= pend_n_next;
      shadow_reg   <= shadow_next;
      exp_clk_reg  <= exp_clk_next;
      applied_reg  <= applied_next;
      err_zero_reg <= err_zero_next;
      err_sync_reg <= err_sync_next;
    end
  end

`ifdef CLK_DIV_CFG_RESYNC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unsync_reg   <= 1'b0;
      div_prev_reg <= 1'b0;
    end else begin
      unsync_reg   <= unsync_next;
      div_prev_reg <= div_clk_out;
    end
  end
`endif

  assign cfg_ready = (state_reg == IDLE);
  assign busy      = (state_reg == PEND) | blocked;
  assign n_out     = n_out_reg;
  assign applied   = applied_reg;
  assign err_zero  = err_zero_reg;
  assign err_sync  = err_sync_reg;

endmodule

// File: tb/tb_clk_div_cfg.sv
// Directed bench for clk_div_cfg, driving div_clk_out from a behavioural divider that follows n_out.
module tb_clk_div_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_n = '0;
  logic        cfg_ready;
  logic        div_clk_out;
  logic [31:0] n_out;
  logic        busy;
  logic        applied;
  logic        err_zero;
  logic        err_sync;
  logic        err_clr = 1'b0;

  logic [31:0] div_cnt;
  logic        div_clk;
  logic        inv = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clk_div_cfg #(.WIDTH(32), .N_RESET(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_n      (cfg_n),
    .cfg_ready  (cfg_ready),
    .div_clk_out(div_clk_out),
    .n_out      (n_out),
    .busy       (busy),
    .applied    (applied),
    .err_zero   (err_zero),
    .err_sync   (err_sync),
    .err_clr    (err_clr)
  );

  // The real divider: it takes its n straight from n_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      div_clk <= 1'b0;
    end else if (div_cnt == n_out - 32'd1) begin
      div_cnt <= '0;
      div_clk <= ~div_clk;
    end else begin
      div_cnt <= div_cnt + 32'd1;
    end
  end

  assign div_clk_out = div_clk ^ inv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
    $display("check %s: got=%0d want=%0d", tag, got, want);
  endtask

  // Cycles until div_clk_out next changes, or bound+1 if it never does.
  task automatic half_period(input int bound, output int cycles);
    logic d0;
    d0 = div_clk_out;
    cycles = bound + 1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (div_clk_out != d0) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Offer n, then wait (bounded by the old factor) for the applied pulse.
  task automatic do_req(input logic [31:0] n, input int n_old, input string tag);
    int lat;
    cfg_valid = 1'b1;
    cfg_n     = n;
    @(negedge clk);
    cfg_valid = 1'b0;
    check({tag, "_ready_low"}, {31'd0, cfg_ready}, 32'd0);
    lat = n_old + 1;
    for (int i = 1; i <= n_old; i++) begin
      @(negedge clk);
      if (applied) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency_ok"}, {31'd0, (lat <= n_old)}, 32'd1);
    check({tag, "_n_out"}, n_out, n);
  endtask

  initial begin
    int  hp;
    int  sync_bad;
    int  app_cnt;
    logic prev;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_n_out", n_out, 32'd2);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_applied", {31'd0, applied}, 32'd0);
    check("rst_err_zero", {31'd0, err_zero}, 32'd0);
    check("rst_err_sync", {31'd0, err_sync}, 32'd0);
    rst = 1'b0;

    // 100 idle cycles with n=2
    sync_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (err_sync) sync_bad++;
    end
    check("idle_err_sync_cycles", sync_bad, 0);
    check("idle_n_out", n_out, 32'd2);

    // Request 5 with divider count at 0 (mid-period for n=2)
    cfg_valid = 1'b1;
    cfg_n     = 32'd5;
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_n     = 32'd3;
    check("req5_ready", {31'd0, cfg_ready}, 32'd0);
    check("req5_busy", {31'd0, busy}, 32'd1);
    check("req5_n_out_hold", n_out, 32'd2);
    check("req5_applied_early", {31'd0, applied}, 32'd0);
    @(negedge clk);
    check("req5_n_out", n_out, 32'd5);
    check("req5_applied", {31'd0, applied}, 32'd1);
    check("req5_busy_clr", {31'd0, busy}, 32'd0);
    check("req5_ready_back", {31'd0, cfg_ready}, 32'd1);
    app_cnt = 0;
    prev = div_clk_out;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (applied) app_cnt++;
    end
    check("req5_applied_once", app_cnt, 0);
    check("req5_first_half_toggle", {31'd0, (div_clk_out != prev)}, 32'd1);
    half_period(12, hp);
    check("req5_half_period", hp, 5);
    check("req5_err_sync", {31'd0, err_sync}, 32'd0);

    // Same factor again, then 7, then 1
    do_req(32'd5, 5, "same5");
    check("same5_busy", {31'd0, busy}, 32'd0);
    do_req(32'd7, 5, "req7");
    do_req(32'd1, 7, "req1");
    sync_bad = 0;
    for (int i = 0; i < 4; i++) begin
      prev = div_clk_out;
      @(negedge clk);
      if (div_clk_out == prev) sync_bad++;
    end
    check("n1_toggle_every_cycle", sync_bad, 0);
    check("n1_err_sync", {31'd0, err_sync}, 32'd0);

    // Zero request
    cfg_valid = 1'b1;
    cfg_n     = 32'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("zero_err", {31'd0, err_zero}, 32'd1);
    check("zero_ready", {31'd0, cfg_ready}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_n_out", n_out, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("zero_clr", {31'd0, err_zero}, 32'd0);
    cfg_valid = 1'b1;
    err_clr   = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    err_clr   = 1'b0;
    check("zero_set_beats_clr", {31'd0, err_zero}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("zero_clr2", {31'd0, err_zero}, 32'd0);

    // Reset while a request for 9 is pending
    cfg_valid = 1'b1;
    cfg_n     = 32'd9;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("pend9_busy", {31'd0, busy}, 32'd1);
    check("pend9_n_out", n_out, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_pend_busy", {31'd0, busy}, 32'd0);
    check("rst_pend_n_out", n_out, 32'd2);
    check("rst_pend_ready", {31'd0, cfg_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    half_period(6, hp);
    check("post_rst_first_half", hp, 2);
    half_period(6, hp);
    check("post_rst_half", hp, 2);
    repeat (12) @(negedge clk);
    check("post_rst_n_out", n_out, 32'd2);
    check("post_rst_err_sync", {31'd0, err_sync}, 32'd0);

    // One-cycle inversion of div_clk_out
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    check("glitch_err_sync", {31'd0, err_sync}, 32'd1);
    check("glitch_n_out", n_out, 32'd2);
`ifndef CLK_DIV_CFG_RESYNC_EN
    check("glitch_busy", {31'd0, busy}, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("glitch_clr", {31'd0, err_sync}, 32'd0);
    repeat (10) @(negedge clk);
    check("glitch_stays_clr", {31'd0, err_sync}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
